fb_burst_sched: RTL
===================

Name: fb_burst_sched

Overview:
- Frame-buffer burst scheduler for the AXI HP frame delayer.
- Generates the write-side and read-side burst start addresses, one 16-beat, 128-byte burst per request.
- Rotates three frame buffers in DDR on each vertical sync, and caps outstanding bursts per channel.
- Sits between the pixel FIFOs (which raise burst requests) and the AXI AW/AR address channels, in the `clk_i` video domain.

Parameters:
- H_WIDTH, 1920: active pixels per line.
- V_HEIGHT, 1080: active lines per frame.
- BASE, 32'h2000000: DDR byte address of buffer 0.
- FRAME_STRIDE, 32'h800000: byte distance between buffers; must be ≥ H_WIDTH*V_HEIGHT*4.
- MAX_OUT, 4: maximum outstanding bursts per channel.
- VS_POL, 1: active level of vs_i (1 = high).

Ports:
- clk_i  in  1  video/AXI clock.
- rst_ni  in  1  reset; synchronous, active-low.
- wen_i  in  1  write channel enable.
- ren_i  in  1  read channel enable.
- vs_i  in  1  vertical sync from video input.
- w_req_i  in  1  write FIFO holds ≥1 burst (16 beats).
- w_addr_o  out  32  write burst address.
- w_valid_o  out  1  write address valid.
- w_ready_i  in  1  AW accepted.
- w_done_i  in  1  one B response received (1-cycle pulse).
- r_req_i  in  1  read FIFO has room for ≥1 burst.
- r_addr_o  out  32  read burst address.
- r_valid_o  out  1  read address valid.
- r_ready_i  in  1  AR accepted.
- r_done_i  in  1  one RLAST beat accepted (1-cycle pulse).
- w_idx_o  out  2  buffer being written.
- r_idx_o  out  2  buffer being read.
- frame_valid_o  out  1  r_idx_o holds a complete frame.
- drop_cnt_o  out  8  frames dropped (saturating).

Behaviour:
- Burst geometry:
  - Pixel = 32 bits, 2 pixels/beat, 16 beats/burst.
  - NB = H_WIDTH*V_HEIGHT/32 bursts per frame; elaboration error if not an integer.
  - Address = BASE + idx*FRAME_STRIDE + cnt*128, in 32-bit arithmetic; cnt is 0..NB-1.
- Reset values:
  - All valid outputs 0; w_idx_o=0, r_idx_o=0; frame_valid_o=0; drop_cnt_o=0.
  - Counters 0; swap-pending flag 0.
- VS edge detection:
  - vs_i is registered once; an edge is a transition to level VS_POL.
  - The edge sets swap_pend, even if swap_pend is already set.
- Write issue:
  - w_valid_o rises the cycle after w_req_i & wen_i & wcnt<NB & wout<MAX_OUT & !swap_pend.
  - Once high, w_valid_o and w_addr_o are held stable until w_ready_i (AXI rule).
  - A change of wen_i or w_req_i does not retract an asserted valid.
  - On handshake: wcnt+1, wout+1.
  - On w_done_i: wout-1. Handshake and done in the same cycle leave wout unchanged.
  - wout never underflows; a done with wout=0 is ignored.
- Read issue:
  - Identical to write, using r_* signals, rcnt and rout.
  - Additionally gated by frame_valid_o.
- Swap application:
  - A swap executes in the first cycle with swap_pend=1, w_valid_o=0 and r_valid_o=0.
  - Write complete means wcnt==NB & wout==0.
  - If complete: last:=w_idx, frame_valid:=1, w_idx:=(w_idx+1) mod 3.
  - Otherwise: w_idx unchanged, drop_cnt_o:=min(drop_cnt_o+1, 255).
  - In both cases: r_idx:=last if a last exists (r_idx unchanged otherwise); wcnt:=0, rcnt:=0; swap_pend:=0.
  - wout and rout carry over; late completions still decrement them.
  - w_idx never equals r_idx once frame_valid_o=1.
- Excess requests with cnt==NB are ignored until the next swap.
- wen_i=0 or ren_i=0 blocks new issue only; swaps still occur.
- rst_ni low aborts everything; outstanding AXI transactions are the system's responsibility.
- Latency: request to valid is 1 cycle; handshake back-to-back is allowed, so a burst can issue every cycle when ready is held.

Decomposition:
- Package fb_sched_pkg holds:
  - BURST_BEATS=16, BEAT_BYTES=8, BURST_BYTES=128, N_BUF=3;
  - the 2-bit buffer-index typedef;
  - the helper function for (idx+1) mod 3.
- One sub-module fb_burst_chan, instantiated twice (write, read):
  - owns cnt/out counters, the valid/addr register, and the issue gating;
  - inputs: idx, enable, clear, req, ready, done.
- The top holds VS edge detection, swap logic and buffer rotation.

Test Plan:
Bench uses H_WIDTH=64, V_HEIGHT=4 (NB=8), MAX_OUT=4, BASE=0x2000000, FRAME_STRIDE=0x1000.
1. Reset, then w_req_i held, w_ready_i=1, no done → exactly 4 handshakes; addresses 0x2000000, 0x2000080, 0x2000100, 0x2000180; w_valid_o stays low until a done pulse.
2. Full frame (8 bursts, 8 dones) then vs edge → w_idx_o=1, r_idx_o=0, frame_valid_o=1; read then issues 0x2000000..0x2000380.
3. vs edge after only 5 write bursts → drop_cnt_o=1, w_idx_o unchanged, next write address restarts at the buffer base.
4. vs edge while w_valid_o=1 and w_ready_i=0 for 3 cycles → address held stable; swap occurs the cycle after handshake with wcnt cleared.
5. w_ready_i and w_done_i together with wout=2 → wout stays 2; 9th w_req_i in the frame → no issue.
6. 256 consecutive incomplete frames → drop_cnt_o saturates at 255; rst_ni low mid-burst → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fb_sched_pkg.sv
// Shared constants, buffer-index type and triple-buffer rotation helper
// for the frame-buffer burst scheduler.
package fb_sched_pkg;

  localparam int unsigned BURST_BEATS = 16;
  localparam int unsigned BEAT_BYTES  = 8;
  localparam int unsigned BURST_BYTES = 128;
  localparam int unsigned N_BUF       = 3;

  typedef logic [1:0] buf_idx_t;

  function automatic buf_idx_t next_buf(input buf_idx_t idx);
    if (idx == buf_idx_t'(N_BUF - 1)) begin
      return 2'd0;
    end else begin
      return idx + 2'd1;
    end
  endfunction

endpackage

// File: rtl/fb_burst_chan.sv
// One AXI address channel: burst counter, outstanding counter and the
// valid/address register, with the issue gating for new bursts.
module fb_burst_chan
  import fb_sched_pkg::*;
#(
  parameter int unsigned NB           = 64800,
  parameter int unsigned MAX_OUT      = 4,
  parameter logic [31:0] BASE         = 32'h0200_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0080_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  buf_idx_t    idx_i,
  input  logic        en_i,
  input  logic        block_i,
  input  logic        clr_i,
  input  logic        req_i,
  input  logic        ready_i,
  input  logic        done_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output logic        complete_o
);

  localparam int CW = $clog2(NB + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_out;
  logic          r_valid;
  logic [31:0]   r_addr;

  logic [CW-1:0] w_cnt_nxt;
  logic [OW-1:0] w_out_nxt;
  logic          w_hs;
  logic          w_dec;
  logic          w_issue;
  logic [31:0]   w_addr_nxt;

  // Next counter values; the issue decision looks at them so a burst can
  // follow a handshake in the very next cycle.
  always_comb begin
    w_hs  = r_valid & ready_i;
    w_dec = done_i & (r_out != '0);
    if (clr_i) begin
      w_cnt_nxt = '0;
    end else if (w_hs) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
    case ({w_hs, w_dec})
      2'b10:   w_out_nxt = r_out + OW'(1);
      2'b01:   w_out_nxt = r_out - OW'(1);
      default: w_out_nxt = r_out;
    endcase
    w_issue = en_i & req_i & ~block_i
            & (w_cnt_nxt < CW'(NB)) & (w_out_nxt < OW'(MAX_OUT));
    w_addr_nxt = BASE + 32'(idx_i) * FRAME_STRIDE
               + 32'(w_cnt_nxt) * 32'(BURST_BYTES);
  end

  // Valid and address only change while idle or on acceptance.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_addr  <= 32'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_out <= w_out_nxt;
      if (!r_valid || ready_i) begin
        r_valid <= w_issue;
        if (w_issue) begin
          r_addr <= w_addr_nxt;
        end
      end
    end
  end

  assign valid_o    = r_valid;
  assign addr_o     = r_addr;
  assign complete_o = (r_cnt == CW'(NB)) && (r_out == '0);

endmodule

// File: rtl/fb_burst_sched.sv
// Frame-buffer burst scheduler: vsync edge detection, triple-buffer rotation
// and drop counting around one write and one read burst channel.
module fb_burst_sched
  import fb_sched_pkg::*;
#(
  parameter int unsigned H_WIDTH      = 1920,
  parameter int unsigned V_HEIGHT     = 1080,
  parameter logic [31:0] BASE         = 32'h0200_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0080_0000,
  parameter int unsigned MAX_OUT      = 4,
  parameter logic        VS_POL       = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wen_i,
  input  logic        ren_i,
  input  logic        vs_i,
  input  logic        w_req_i,
  output logic [31:0] w_addr_o,
  output logic        w_valid_o,
  input  logic        w_ready_i,
  input  logic        w_done_i,
  input  logic        r_req_i,
  output logic [31:0] r_addr_o,
  output logic        r_valid_o,
  input  logic        r_ready_i,
  input  logic        r_done_i,
  output logic [1:0]  w_idx_o,
  output logic [1:0]  r_idx_o,
  output logic        frame_valid_o,
  output logic [7:0]  drop_cnt_o
);

  localparam int unsigned PIX_PER_BURST = BURST_BEATS * BEAT_BYTES / 4;
  localparam int unsigned NB            = H_WIDTH * V_HEIGHT / PIX_PER_BURST;

  if ((H_WIDTH * V_HEIGHT) % PIX_PER_BURST != 0) begin : g_nb_check
    $error("fb_burst_sched: frame is not a whole number of bursts");
  end
  if (H_WIDTH * V_HEIGHT * 4 > FRAME_STRIDE) begin : g_stride_check
    $error("fb_burst_sched: FRAME_STRIDE smaller than one frame");
  end

  logic     r_vs;
  logic     r_swap_pend;
  buf_idx_t r_w_idx;
  buf_idx_t r_r_idx;
  logic     r_frame_valid;
  logic [7:0] r_drop_cnt;

  logic w_vs_edge;
  logic w_swap;
  logic w_w_complete;
  logic w_unused_r_complete;

  assign w_vs_edge = (vs_i == VS_POL) && (r_vs != VS_POL);
  assign w_swap    = r_swap_pend & ~w_valid_o & ~r_valid_o;

  // A swap waits for both address channels to be idle so no held
  // address is ever rewritten.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_vs          <= ~VS_POL;
      r_swap_pend   <= 1'b0;
      r_w_idx       <= 2'd0;
      r_r_idx       <= 2'd0;
      r_frame_valid <= 1'b0;
      r_drop_cnt    <= 8'd0;
    end else begin
      r_vs <= vs_i;
      if (w_vs_edge) begin
        r_swap_pend <= 1'b1;
      end else if (w_swap) begin
        r_swap_pend <= 1'b0;
      end
      if (w_swap) begin
        if (w_w_complete) begin
          r_r_idx       <= r_w_idx;
          r_w_idx       <= next_buf(r_w_idx);
          r_frame_valid <= 1'b1;
        end else if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  fb_burst_chan #(
    .NB(NB), .MAX_OUT(MAX_OUT), .BASE(BASE), .FRAME_STRIDE(FRAME_STRIDE)
  ) u_wr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .idx_i      (r_w_idx),
    .en_i       (wen_i),
    .block_i    (r_swap_pend),
    .clr_i      (w_swap),
    .req_i      (w_req_i),
    .ready_i    (w_ready_i),
    .done_i     (w_done_i),
    .valid_o    (w_valid_o),
    .addr_o     (w_addr_o),
    .complete_o (w_w_complete)
  );

  // Reads stay parked until a complete frame exists to read from.
  fb_burst_chan #(
    .NB(NB), .MAX_OUT(MAX_OUT), .BASE(BASE), .FRAME_STRIDE(FRAME_STRIDE)
  ) u_rd (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .idx_i      (r_r_idx),
    .en_i       (ren_i),
    .block_i    (r_swap_pend | ~r_frame_valid),
    .clr_i      (w_swap),
    .req_i      (r_req_i),
    .ready_i    (r_ready_i),
    .done_i     (r_done_i),
    .valid_o    (r_valid_o),
    .addr_o     (r_addr_o),
    .complete_o (w_unused_r_complete)
  );

  assign w_idx_o       = r_w_idx;
  assign r_idx_o       = r_r_idx;
  assign frame_valid_o = r_frame_valid;
  assign drop_cnt_o    = r_drop_cnt;

endmodule
